// File: rtl/ex_mem_stage_if.sv
// Execute-to-memory stage bus: upstream instruction handshake, downstream entry
// handshake, flush and branch resolution outputs.
interface ex_mem_stage_if #(
  parameter int N     = 32,
  parameter int REG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     alu_result;
  logic             flag_cero;
  logic [N-1:0]     store_data;
  logic [REG_W-1:0] rd;
  logic             reg_write;
  logic             mem_write;
  logic             branch;
  logic             branch_ne;
  logic [N-1:0]     branch_target;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_alu_result;
  logic [N-1:0]     out_store_data;
  logic [REG_W-1:0] out_rd;
  logic             out_reg_write;
  logic             out_mem_write;
  logic             branch_taken;
  logic [N-1:0]     branch_pc;

  modport master (
    output in_valid, alu_result, flag_cero, store_data, rd, reg_write, mem_write,
           branch, branch_ne, branch_target, flush, out_ready,
    input  in_ready, out_valid, out_alu_result, out_store_data, out_rd,
           out_reg_write, out_mem_write, branch_taken, branch_pc
  );

  modport slave (
    input  in_valid, alu_result, flag_cero, store_data, rd, reg_write, mem_write,
           branch, branch_ne, branch_target, flush, out_ready,
    output in_ready, out_valid, out_alu_result, out_store_data, out_rd,
           out_reg_write, out_mem_write, branch_taken, branch_pc
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built as a 2-entry skid buffer with optional branch
// resolution, enabled by defining EX_MEM_BRANCH_RESOLVE_EN.
module ex_mem_stage #(
  parameter int N     = 32,
  parameter int REG_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  ex_mem_stage_if.slave  bus,
  output logic [1:0]     o_dbg_state
);

  // Handshake: a side transfers on the clock edge where its valid and ready are
  // both 1; in_ready is registered, out_valid follows state, flush kills input.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [N-1:0]     alu_result;
    logic [N-1:0]     store_data;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_write;
  } entry_t;

  state_t r_state;
  state_t w_state_nxt;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_main_nxt;
  entry_t w_skid_nxt;
  entry_t w_in_entry;
  logic   r_in_ready;
  logic   w_in_fire;
  logic   w_out_fire;

  assign w_in_entry = {bus.alu_result, bus.store_data, bus.rd, bus.reg_write, bus.mem_write};
  assign w_in_fire  = bus.in_valid && r_in_ready && !bus.flush;
  assign w_out_fire = (r_state != S_EMPTY) && bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = S_ONE;
          w_main_nxt  = w_in_entry;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_nxt = w_in_entry;
        end else if (w_in_fire) begin
          w_state_nxt = S_TWO;
          w_skid_nxt  = w_in_entry;
        end else if (w_out_fire) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_out_fire) begin
          w_state_nxt = S_ONE;
          w_main_nxt  = r_skid;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Any consumption this cycle has already happened; flush just drops the rest.
    if (bus.flush) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_in_ready <= (w_state_nxt != S_TWO);
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.out_valid      = (r_state != S_EMPTY);
  assign bus.out_alu_result = r_main.alu_result;
  assign bus.out_store_data = r_main.store_data;
  assign bus.out_rd         = r_main.rd;
  assign bus.out_reg_write  = r_main.reg_write;
  assign bus.out_mem_write  = r_main.mem_write;
  assign o_dbg_state        = r_state;

`ifdef EX_MEM_BRANCH_RESOLVE_EN
  logic         r_branch_taken;
  logic [N-1:0] r_branch_pc;
  logic         w_take;

  // BEQ takes on zero, BNE on non-zero.
  assign w_take = w_in_fire && bus.branch && (bus.flag_cero ^ bus.branch_ne);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_taken <= 1'b0;
      r_branch_pc    <= '0;
    end else begin
      r_branch_taken <= w_take;
      if (w_take) begin
        r_branch_pc <= bus.branch_target;
      end
    end
  end

  assign bus.branch_taken = r_branch_taken;
  assign bus.branch_pc    = r_branch_pc;
`else
  logic w_unused_branch;
  assign w_unused_branch  = ^{bus.branch, bus.branch_ne, bus.flag_cero, bus.branch_target};
  assign bus.branch_taken = 1'b0;
  assign bus.branch_pc    = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic, checked by a
// negedge monitor against a queue-based FIFO model.
module tb_ex_mem_stage;
  localparam int N     = 32;
  localparam int REG_W = 5;
  localparam int W     = 2 * N + REG_W + 2;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  ex_mem_stage_if #(.N(N), .REG_W(REG_W)) bus ();

  ex_mem_stage #(.N(N), .REG_W(REG_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [W-1:0] exp_q[$];   // held entries first, then any entry pushed this cycle
  int           cnt;         // entries currently held by the stage
  logic         exp_bt;
  logic [N-1:0] exp_pc;
  logic         chk_zero;
  int           n_checks;
  int           n_fail;

  function automatic logic [W-1:0] pack(input logic [N-1:0] alu, input logic [N-1:0] sd,
                                        input logic [REG_W-1:0] rd, input logic rw,
                                        input logic mw);
    return {alu, sd, rd, rw, mw};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [N-1:0] alu, input logic [N-1:0] sd,
                       input logic [REG_W-1:0] rd, input logic rw, input logic mw,
                       input logic br, input logic ne, input logic z,
                       input logic [N-1:0] tgt, input logic fl, input logic ordy);
    @(posedge clk);
    #2;
    bus.in_valid      = iv;
    bus.alu_result    = alu;
    bus.store_data    = sd;
    bus.rd            = rd;
    bus.reg_write     = rw;
    bus.mem_write     = mw;
    bus.branch        = br;
    bus.branch_ne     = ne;
    bus.flag_cero     = z;
    bus.branch_target = tgt;
    bus.flush         = fl;
    bus.out_ready     = ordy;
    if (iv && !fl && cnt < 2) exp_q.push_back(pack(alu, sd, rd, rw, mw));
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, ordy);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic         out_fire;
    logic         in_fire;
    logic         next_bt;
    if (reset) begin
      exp_q.delete();
      cnt      = 0;
      exp_bt   = 1'b0;
      exp_pc   = '0;
      chk_zero = 1'b1;
    end else begin
      check("out_valid", bus.out_valid, cnt > 0);
      check("in_ready", bus.in_ready, cnt < 2);
      if (cnt > 0)
        check("entry", pack(bus.out_alu_result, bus.out_store_data, bus.out_rd,
                            bus.out_reg_write, bus.out_mem_write), exp_q[0]);
      if (chk_zero) begin
        check("reset_data", pack(bus.out_alu_result, bus.out_store_data, bus.out_rd,
                                 bus.out_reg_write, bus.out_mem_write), '0);
        chk_zero = 1'b0;
      end
      check("branch_taken", bus.branch_taken, exp_bt);
      check("branch_pc", bus.branch_pc, exp_pc);

      in_fire  = bus.in_valid && (cnt < 2) && !bus.flush;
      out_fire = (cnt > 0) && bus.out_ready;
      next_bt  = 1'b0;
`ifdef EX_MEM_BRANCH_RESOLVE_EN
      if (in_fire && bus.branch && (bus.flag_cero != bus.branch_ne)) begin
        next_bt = 1'b1;
        exp_pc  = bus.branch_target;
      end
`endif
      if (out_fire) begin
        void'(exp_q.pop_front());
        cnt--;
      end
      if (bus.flush) begin
        exp_q.delete();
        cnt = 0;
      end else if (in_fire) begin
        cnt++;
      end
      exp_bt = next_bt;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    cnt      = 0;
    exp_bt   = 1'b0;
    exp_pc   = '0;
    chk_zero = 1'b0;
    reset    = 1'b1;
    bus.in_valid = 1'b0;  bus.alu_result = '0;    bus.store_data = '0;
    bus.rd = '0;          bus.reg_write = 1'b0;   bus.mem_write = 1'b0;
    bus.branch = 1'b0;    bus.branch_ne = 1'b0;   bus.flag_cero = 1'b0;
    bus.branch_target = '0; bus.flush = 1'b0;     bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    // single entry, one-cycle latency
    idle(1'b1);
    drive(1'b1, 32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // backpressure: A then B fill both slots, then drain in order
    drive(1'b1, 32'h1, 32'hA1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 32'h2, 32'hB2, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 32'h3, 32'hC3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // BEQ taken, BEQ not taken, BNE taken
    drive(1'b1, 32'h5, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    drive(1'b1, 32'h6, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h90, 1'b0, 1'b1);
    idle(1'b1);
    drive(1'b1, 32'h7, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // flush while full, with a taken branch presented at the same time
    drive(1'b1, 32'h11, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0);
    drive(1'b1, 32'h33, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hC0, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // reset with two entries held
    drive(1'b1, 32'h55, 32'h1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 32'h66, 32'h2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    apply_reset();
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, REG_W'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    end
    repeat (4) idle(1'b1);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter N, default 32: datapath width of ALU result, store data and branch target.
REQ-002 Parameter REG_W, default 5: destination register index width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  execute stage presents a valid instruction.
REQ-007 in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 alu_result  input  N  ALU sum/difference.
REQ-009 flag_cero  input  1  ALU zero flag.
REQ-010 store_data  input  N  rs2 value for stores.
REQ-011 rd  input  REG_W  destination register.
REQ-012 reg_write, mem_write  input  1 each  write-enable controls.
REQ-013 branch, branch_ne  input  1 each  conditional branch; 0 = BEQ, 1 = BNE.
REQ-014 branch_target  input  N  computed branch PC.
REQ-015 flush  input  1  discard all held and incoming instructions.
REQ-016 out_valid  output  1  memory stage entry valid.
REQ-017 out_ready  input  1  memory stage consumes the entry.
REQ-018 out_alu_result, out_store_data (N), out_rd (REG_W), out_reg_write, out_mem_write (1)  outputs  registered entry fields.
REQ-019 branch_taken  output  1  one-cycle pulse, resolved branch taken.
REQ-020 branch_pc  output  N  target PC, valid when branch_taken=1.

Function
REQ-021 The stage SHALL be a 2-entry skid buffer (main + skid) with states EMPTY, ONE, TWO.
REQ-022 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-023 in_ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in TWO.
REQ-024 out_valid SHALL be 1 in ONE and TWO; outputs always present the main entry.
REQ-025 EMPTY + in -> ONE, with the accepted entry visible on outputs the next cycle (1-cycle latency).
REQ-026 ONE + in + out -> ONE, main loaded with the new entry; ONE + in, no out -> TWO, new entry in skid; ONE + out, no in -> EMPTY.
REQ-027 TWO + out -> ONE, skid moved to main; TWO, no out -> TWO, both entries held stable.
REQ-028 Entry order SHALL be preserved; no entry is dropped or duplicated.
REQ-029 Output fields SHALL stay stable while out_valid=1 and out_ready=0.
REQ-030 flush=1 SHALL force EMPTY next cycle, ignore in_valid that cycle, and suppress branch_taken for that cycle's input.
REQ-031 flush takes priority over simultaneous in/out transfers; an out transfer in the flush cycle still counts as consumed.
REQ-032 branch_taken SHALL pulse the cycle after a transfer in with branch=1 and (flag_cero XOR branch_ne)=1; branch_pc = branch_target captured at that transfer.
REQ-033 branch_taken SHALL be 0 in all other cycles; branch_pc holds its last value.
REQ-034 Entries SHALL be captured unmodified; no width conversion or arithmetic.

Reset
REQ-035 On reset: state EMPTY, in_ready=1, out_valid=0, branch_taken=0, all data outputs and branch_pc=0.
REQ-036 Reset SHALL override flush and all transfers; reset mid-operation discards held entries.

Configuration
REQ-037 Macro EX_MEM_BRANCH_RESOLVE_EN defined: branch resolution per REQ-032/033 is compiled in.
REQ-038 Macro undefined: branch_taken tied 0, branch_pc tied 0, and the branch, branch_ne, flag_cero and branch_target inputs are ignored; ports remain.

Verification
REQ-039 Reset, then in_valid=1, alu_result=0x00000010, rd=3, out_ready=1 -> next cycle out_valid=1, out_alu_result=0x10, out_rd=3.
REQ-040 out_ready=0; send A=0x1, B=0x2 on consecutive cycles -> in_ready=0 after B, outputs hold A; out_ready=1 -> A, then B; in_ready=1.
REQ-041 BEQ: branch=1, branch_ne=0, flag_cero=1, branch_target=0x80 -> branch_taken=1 for exactly one cycle, branch_pc=0x80; flag_cero=0 -> no pulse.
REQ-042 BNE: branch_ne=1, flag_cero=0, branch_target=0x44 -> pulse with branch_pc=0x44.
REQ-043 In TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no branch pulse.
REQ-044 Macro undefined, taken-BEQ stimulus as in REQ-041 -> branch_taken stays 0; data path behaves per REQ-039.
